// File: rtl/fnd_display_scheduler.sv
// Produces the packed-BCD word for the 8-digit FND: periodic speed sampling with a
// bit-serial double-dabble converter, pre-empted by a level-sensitive override source.
module fnd_display_scheduler #(
   parameter int unsigned CLK_FREQ  = 1_000,
   parameter int unsigned UPDATE_HZ = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [26:0] speed_bin,
   input  logic        ovr_req,
   input  logic [31:0] ovr_value,
   output logic [31:0] value,
   output logic        value_upd,
   output logic        busy,
   output logic        src_ovr,
   output logic        sat
);

   localparam int unsigned UpdateCnt =
      (UPDATE_HZ == 0) ? 1 : (CLK_FREQ + UPDATE_HZ - 1) / UPDATE_HZ;
   localparam int unsigned TickW = (UpdateCnt > 1) ? $clog2(UpdateCnt) : 1;
   localparam logic [26:0] SpeedMax = 27'd99_999_999;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e            state_q, state_d;
   logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
   logic [26:0]       bin_sh_q, bin_sh_d;
   logic [31:0]       bcd_q, bcd_d, bcd_adj;
   logic [4:0]        bitcnt_q, bitcnt_d;
   logic              sat_nx_q, sat_nx_d;
   logic [31:0]       value_q, value_d;
   logic              value_upd_q, value_upd_d;
   logic              src_ovr_q, src_ovr_d;
   logic              sat_q, sat_d;
   logic              tick;
   logic              over_max;

   assign tick       = (tick_cnt_q == TickW'(UpdateCnt - 1));
   assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
   assign over_max   = (speed_bin > SpeedMax);

   always_comb begin
      bcd_adj = '0;
      for (int i = 0; i < 8; i++) begin
         bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3
                                                       : bcd_q[i*4 +: 4];
      end
   end

   always_comb begin
      state_d     = state_q;
      bin_sh_d    = bin_sh_q;
      bcd_d       = bcd_q;
      bitcnt_d    = bitcnt_q;
      sat_nx_d    = sat_nx_q;
      value_d     = value_q;
      value_upd_d = 1'b0;
      src_ovr_d   = src_ovr_q;
      sat_d       = sat_q;
      if (ovr_req) begin
         // Override aborts any conversion; only a changed word (or source switch) re-strobes.
         state_d = StIdle;
         if ((value_q != ovr_value) || !src_ovr_q) begin
            value_d     = ovr_value;
            src_ovr_d   = 1'b1;
            sat_d       = 1'b0;
            value_upd_d = 1'b1;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (tick) begin
                  state_d  = StShift;
                  sat_nx_d = over_max;
                  bin_sh_d = over_max ? SpeedMax : speed_bin;
                  bcd_d    = '0;
                  bitcnt_d = 5'd27;
               end
            end
            StShift: begin
               {bcd_d, bin_sh_d} = {bcd_adj[30:0], bin_sh_q, 1'b0};
               bitcnt_d          = bitcnt_q - 5'd1;
               if (bitcnt_q == 5'd1) state_d = StDone;
            end
            StDone: begin
               state_d     = StIdle;
               value_d     = bcd_q;
               sat_d       = sat_nx_q;
               src_ovr_d   = 1'b0;
               value_upd_d = 1'b1;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         tick_cnt_q  <= '0;
         bin_sh_q    <= '0;
         bcd_q       <= '0;
         bitcnt_q    <= '0;
         sat_nx_q    <= 1'b0;
         value_q     <= '0;
         value_upd_q <= 1'b0;
         src_ovr_q   <= 1'b0;
         sat_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         bin_sh_q    <= bin_sh_d;
         bcd_q       <= bcd_d;
         bitcnt_q    <= bitcnt_d;
         sat_nx_q    <= sat_nx_d;
         value_q     <= value_d;
         value_upd_q <= value_upd_d;
         src_ovr_q   <= src_ovr_d;
         sat_q       <= sat_d;
      end
   end

   assign value     = value_q;
   assign value_upd = value_upd_q;
   assign busy      = (state_q != StIdle);
   assign src_ovr   = src_ovr_q;
   assign sat       = sat_q;

endmodule

// File: tb/tb_fnd_display_scheduler.sv
// Directed bench for fnd_display_scheduler: a 100-cycle update instance and a
// 20-cycle instance that drops ticks, both sharing clock and reset.
module tb_fnd_display_scheduler;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [26:0] speed_bin = '0;
   logic        ovr_req   = 1'b0;
   logic [31:0] ovr_value = '0;
   logic [31:0] value;
   logic        value_upd, busy, src_ovr, sat;

   logic [26:0] speed_f   = '0;
   logic        ovr_req_f = 1'b0;
   logic [31:0] ovr_val_f = '0;
   logic [31:0] value_f;
   logic        upd_f, busy_f, src_f, sat_f;

   int unsigned cyc = 0;
   int unsigned c0;
   int unsigned last_start;
   int unsigned prev_start;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fnd_display_scheduler #(.CLK_FREQ(1_000), .UPDATE_HZ(10)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .speed_bin (speed_bin),
      .ovr_req   (ovr_req),
      .ovr_value (ovr_value),
      .value     (value),
      .value_upd (value_upd),
      .busy      (busy),
      .src_ovr   (src_ovr),
      .sat       (sat)
   );

   fnd_display_scheduler #(.CLK_FREQ(20), .UPDATE_HZ(1)) dut_fast (
      .clk       (clk),
      .rst_n     (rst_n),
      .speed_bin (speed_f),
      .ovr_req   (ovr_req_f),
      .ovr_value (ovr_val_f),
      .value     (value_f),
      .value_upd (upd_f),
      .busy      (busy_f),
      .src_ovr   (src_f),
      .sat       (sat_f)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Waits for a fresh busy rise, then checks latency, busy width and the result.
   task automatic run_conv(input string tag, input bit fast, input logic [26:0] spd,
                           input logic [31:0] exp_val, input logic exp_sat);
      logic prev;
      bit   ok;
      int   lat;
      int   bcnt;
      if (fast) speed_f = spd;
      else speed_bin = spd;
      prev = fast ? busy_f : busy;
      ok   = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if ((fast ? busy_f : busy) && !prev) begin
            ok = 1'b1;
            break;
         end
         prev = fast ? busy_f : busy;
      end
      check_eq({tag, " start"}, 32'(ok), 32'd1);
      last_start = cyc;
      bcnt = 1;
      lat  = 0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (fast ? upd_f : value_upd) begin
            lat = k;
            break;
         end
         if (fast ? busy_f : busy) bcnt++;
      end
      check_eq({tag, " latency"}, 32'(lat), 32'd28);
      check_eq({tag, " busy_len"}, 32'(bcnt), 32'd28);
      check_eq({tag, " value"}, fast ? value_f : value, exp_val);
      check_eq({tag, " sat"}, 32'(fast ? sat_f : sat), 32'(exp_sat));
      check_eq({tag, " src_ovr"}, 32'(fast ? src_f : src_ovr), 32'd0);
      @(negedge clk);
      check_eq({tag, " upd_width"}, 32'(fast ? upd_f : value_upd), 32'd0);
   endtask

   initial begin
      int  upd_cnt;
      int  busy_cnt;
      bit  ok;

      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst value", value, 32'h0);
      check_eq("rst upd", 32'(value_upd), 32'd0);
      check_eq("rst busy", 32'(busy), 32'd0);
      check_eq("rst src", 32'(src_ovr), 32'd0);
      check_eq("rst sat", 32'(sat), 32'd0);

      rst_n = 1'b1;
      c0    = cyc;
      run_conv("c12345678", 1'b0, 27'd12_345_678, 32'h1234_5678, 1'b0);
      check_eq("first tick", last_start - c0, 32'd100);
      run_conv("c0", 1'b0, 27'd0, 32'h0000_0000, 1'b0);
      run_conv("cmax", 1'b0, 27'd99_999_999, 32'h9999_9999, 1'b0);
      run_conv("csat", 1'b0, 27'd120_000_000, 32'h9999_9999, 1'b1);
      run_conv("c5", 1'b0, 27'd5, 32'h0000_0005, 1'b0);

      // Override 10 cycles into a conversion.
      speed_bin = 27'd9;
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (busy) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq("ovr conv start", 32'(ok), 32'd1);
      repeat (10) @(negedge clk);
      check_eq("ovr busy before", 32'(busy), 32'd1);
      ovr_value = 32'hEEEE_0001;
      ovr_req   = 1'b1;
      @(negedge clk);
      check_eq("ovr busy", 32'(busy), 32'd0);
      check_eq("ovr value", value, 32'hEEEE_0001);
      check_eq("ovr src", 32'(src_ovr), 32'd1);
      check_eq("ovr sat", 32'(sat), 32'd0);
      check_eq("ovr upd", 32'(value_upd), 32'd1);
      upd_cnt  = 0;
      busy_cnt = 0;
      for (int k = 0; k < 150; k++) begin
         @(negedge clk);
         if (value_upd) upd_cnt++;
         if (busy) busy_cnt++;
      end
      check_eq("ovr hold upd", 32'(upd_cnt), 32'd0);
      check_eq("ovr hold busy", 32'(busy_cnt), 32'd0);
      check_eq("ovr hold value", value, 32'hEEEE_0001);
      ovr_value = 32'hEEEE_0002;
      upd_cnt   = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (value_upd) upd_cnt++;
      end
      check_eq("ovr change upd", 32'(upd_cnt), 32'd1);
      check_eq("ovr change value", value, 32'hEEEE_0002);

      // Drop override well away from a tick so the held word can be observed.
      speed_bin = 27'd42;
      for (int k = 0; k < 100; k++) begin
         if (((cyc - c0) % 100) == 50) break;
         @(negedge clk);
      end
      ovr_req = 1'b0;
      upd_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (value_upd) upd_cnt++;
      end
      check_eq("ovr fall upd", 32'(upd_cnt), 32'd0);
      check_eq("ovr fall value", value, 32'hEEEE_0002);
      check_eq("ovr fall src", 32'(src_ovr), 32'd1);
      run_conv("c42", 1'b0, 27'd42, 32'h0000_0042, 1'b0);

      // Asynchronous reset in the middle of SHIFT.
      run_conv("csat2", 1'b0, 27'd120_000_001, 32'h9999_9999, 1'b1);
      speed_bin = 27'd777;
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (busy) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq("rst conv start", 32'(ok), 32'd1);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("async value", value, 32'h0);
      check_eq("async busy", 32'(busy), 32'd0);
      check_eq("async sat", 32'(sat), 32'd0);
      check_eq("async src", 32'(src_ovr), 32'd0);
      check_eq("async upd", 32'(value_upd), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      c0    = cyc;
      run_conv("c777", 1'b0, 27'd777, 32'h0000_0777, 1'b0);
      check_eq("post rst tick", last_start - c0, 32'd100);

      // Fast instance: ticks every 20 cycles, so one in two is dropped.
      run_conv("f314", 1'b1, 27'd31_415_926, 32'h3141_5926, 1'b0);
      prev_start = last_start;
      run_conv("fsat", 1'b1, 27'd100_000_000, 32'h9999_9999, 1'b1);
      check_eq("fast period1", last_start - prev_start, 32'd40);
      prev_start = last_start;
      run_conv("f64", 1'b1, 27'd64, 32'h0000_0064, 1'b0);
      check_eq("fast period2", last_start - prev_start, 32'd40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
